display_message_scanner: RTL
============================

Name: display_message_scanner

Overview:
- Parametrised successor to the status-to-character selector for the multiplexed 7-segment display.
- Generates its own digit scan from a prescaler instead of external scan clocks.
- Latches the prioritised status message only at frame boundaries, so a frame never mixes two messages.
- Adds a sticky, acknowledgeable error flag and optional error blinking. Feeds the 7-segment decoder, which maps Output codes to segments, and drives the digit anodes.

Parameters:
NUM_DIGITS, 4, number of scanned digits (4..8); digits 4..NUM_DIGITS-1 always show BLANK_CODE
SCAN_DIV, 1000, Clock cycles per digit slot (>=2)
BLINK_FRAMES, 64, frames per blink half-period (>=1)
CODE_W, 4, character code width
BLANK_CODE, 4'b1000, code driven for blank/no message

Ports:
Clock  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
Enable  in  1  scan enable; 0 freezes all counters and outputs
Livre  in  1  status "FrEE", highest priority
Pare  in  1  status "PArE"
Erro  in  1  status "Erro" (level, also sets sticky flag)
Full  in  1  status "FULL", lowest priority
ErroAck  in  1  clears sticky error flag
BlinkEn  in  1  enables blinking while the "Erro" message is shown
Output  out  CODE_W  character code for the currently selected digit
DigitSel  out  NUM_DIGITS  active-low one-hot digit enable
FrameStart  out  1  one-cycle pulse when the scan returns to digit 0
ErroLatched  out  1  sticky error flag

Behaviour:
- Reset (async, ResetN=0):
  - prescaler=0, index=0, MsgReg=NONE, blink counter=0, phase=0.
  - Output=BLANK_CODE, DigitSel=all 1s, FrameStart=0, ErroLatched=0.
- Character codes: F=0000, r=0001, E=0010, P=0011, A=0100, o=0101, U=0110, L=0111, blank=BLANK_CODE.
- Message table, digits 0..3:
  - FREE: F r E E
  - PARE: P A r E
  - ERRO: E r r o
  - FULL: F U L L
  - NONE: all blank
- Prescaler:
  - When Enable=1, counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and the digit index advances.
  - The index wraps from NUM_DIGITS-1 to 0.
- Frame boundary, on the edge where the index wraps to 0:
  - MsgReg loads the priority selection: Livre > Pare > (Erro | ErroLatched) > Full > NONE.
  - FrameStart=1 for exactly that next cycle.
  - Blink counter increments; when it reaches BLINK_FRAMES-1 it resets to 0 and phase toggles.
- Status inputs are ignored between boundaries. A status pulse that starts and ends mid-frame has no display effect, except through the ErroLatched path.
- Output register, updated each Enable=1 cycle:
  - Output <= table(MsgReg, index).
  - DigitSel <= ~(1<<index).
  - Latency: 1 cycle after the index/MsgReg change.
- Blink: if BlinkEn=1, MsgReg=ERRO and phase=1, then Output=BLANK_CODE and DigitSel=all 1s. The scan keeps running. BlinkEn=0 forces visible output immediately (next cycle).
- ErroLatched:
  - Set on any cycle with Erro=1, independent of Enable.
  - Cleared on a cycle with ErroAck=1 and Erro=0.
  - Erro and ErroAck both 1: stays set.
  - Clearing it does not change MsgReg until the next frame boundary.
- Enable=0: prescaler, index, MsgReg, blink state and outputs hold; FrameStart=0. ErroLatched is still updated.
- Reset mid-frame: immediate return to reset values. The first boundary after release occurs after NUM_DIGITS*SCAN_DIV enabled cycles.

Test Plan:
- Reset & first frame (NUM_DIGITS=4, SCAN_DIV=2, Full=1): after ResetN release, Output=1000 for frame 0. FrameStart pulses at enabled cycle 8. Next frame shows 0000,0110,0111,0111 with DigitSel 1110,1101,1011,0111, each held 2 cycles.
- Priority & frame atomicity: Full=1 steady; assert Livre=1 during digit 1 of a frame → remainder of that frame stays FULL; next frame shows 0000,0001,0010,0010.
- Sticky error: 1-cycle Erro pulse mid-frame, no other status → ErroLatched=1; next frame shows 0010,0001,0001,0101. Erro=1 with ErroAck=1 → stays 1. ErroAck alone → 0; next frame shows NONE (1000).
- Blink (BLINK_FRAMES=2, BlinkEn=1, ERRO shown): frames 0-1 visible, frames 2-3 Output=1000 with DigitSel=1111, frames 4-5 visible. Dropping BlinkEn during a blank frame → visible next cycle.
- Enable freeze: drop Enable at digit 2 for 10 cycles → Output, DigitSel and index unchanged, no FrameStart. Resume completes the remaining 2-cycle slot count exactly.
- Wide display (NUM_DIGITS=6, PARE): digits 0-3 show 0011,0100,0001,0010; digits 4-5 show 1000; FrameStart period is 12 enabled cycles.

Source files
------------

// File: rtl/display_message_scanner.sv
// display_message_scanner: self-scanning 7-segment message selector with frame-atomic
// message latching, sticky error flag and optional error blinking.
module display_message_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int CODE_W = 4,
  parameter logic [CODE_W-1:0] BLANK_CODE = 4'b1000
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Enable,
  input  logic                  Livre,
  input  logic                  Pare,
  input  logic                  Erro,
  input  logic                  Full,
  input  logic                  ErroAck,
  input  logic                  BlinkEn,
  output logic [CODE_W-1:0]     Output,
  output logic [NUM_DIGITS-1:0] DigitSel,
  output logic                  FrameStart,
  output logic                  ErroLatched
);
  typedef enum logic [2:0] {NONE, FREE, PARE, ERRO, FULL} msg_t;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic phase, slot_end, frame_end, blank, blink_wrap;
  msg_t msg, sel;
  logic [15:0] row;
  logic [CODE_W-1:0] code;
  always_comb begin
    slot_end = Enable && presc == PW'(SCAN_DIV - 1);
    frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
    blink_wrap = bcnt == BW'(BLINK_FRAMES - 1);
    sel = Livre ? FREE : Pare ? PARE : (Erro || ErroLatched) ? ERRO : Full ? FULL : NONE;
    // four 4-bit character codes per message, digit 0 in the low nibble
    row = msg == FREE ? 16'h2210 : msg == PARE ? 16'h2143 : msg == ERRO ? 16'h5112 : 16'h7760;
    code = (msg == NONE || int'(idx) > 3) ? BLANK_CODE : CODE_W'(row[{idx[1:0], 2'b00} +: 4]);
    blank = BlinkEn && msg == ERRO && phase;
  end
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      presc <= '0;
      idx <= '0;
      msg <= NONE;
      bcnt <= '0;
      phase <= 1'b0;
      Output <= BLANK_CODE;
      DigitSel <= '1;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= frame_end;
      if (Enable) begin
        presc <= slot_end ? '0 : presc + 1'b1;
        if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
        if (frame_end) begin
          msg <= sel;
          bcnt <= blink_wrap ? '0 : bcnt + 1'b1;
          phase <= blink_wrap ? ~phase : phase;
        end
        Output <= blank ? BLANK_CODE : code;
        DigitSel <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
      end
    end
  end
  // the sticky flag tracks Erro even while the scan is frozen
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) ErroLatched <= 1'b0;
    else ErroLatched <= Erro ? 1'b1 : ErroAck ? 1'b0 : ErroLatched;
  end
endmodule
